// File: rtl/a5_keystream_sequencer.sv
// a5_keystream_sequencer
//   Wishbone master that runs one A5/1 keystream session against the A5
//   peripheral: writes KEY_LO/KEY_HI, then for each frame writes FRAME and
//   CONTROL=1 (load), polls STATUS bit0 and reads DATA words, handing each
//   word to downstream logic on a valid/ready stream.
//
//   Optional: define A5SEQ_ID_CHECK_EN to read the ID register first and
//   abort the session (error + done) unless it returns 32'h41354135.
//
// Ports
//   clk, reset_n        clock, asynchronous active-low reset
//   start               one-cycle session request (sampled only in IDLE)
//   key/frame_start/num_frames  session inputs, captured on accepted start
//   busy/done/error     session status (done is a one-cycle pulse,
//                       error is sticky until the next accepted start)
//   ks_data/ks_valid/ks_ready/ks_last  keystream word stream
//   m_*                 Wishbone master port to the A5 peripheral
module a5_keystream_sequencer #(
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
  parameter int          WORDS_PER_FRAME = 8,
  parameter int          POLL_LIMIT      = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [63:0] key,
  input  logic [21:0] frame_start,
  input  logic [15:0] num_frames,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [31:0] ks_data,
  output logic        ks_valid,
  input  logic        ks_ready,
  output logic        ks_last,
  output logic        m_cyc_o,
  output logic        m_stb_o,
  output logic        m_we_o,
  output logic [3:0]  m_sel_o,
  output logic [31:0] m_adr_o,
  output logic [31:0] m_dat_o,
  input  logic [31:0] m_dat_i,
  input  logic        m_ack_i
);

  localparam logic [31:0] OFF_ID      = 32'h00;
  localparam logic [31:0] OFF_STATUS  = 32'h04;
  localparam logic [31:0] OFF_CONTROL = 32'h08;
  localparam logic [31:0] OFF_DATA    = 32'h0C;
  localparam logic [31:0] OFF_KEY_LO  = 32'h10;
  localparam logic [31:0] OFF_KEY_HI  = 32'h14;
  localparam logic [31:0] OFF_FRAME   = 32'h18;
  localparam logic [31:0] ID_VALUE    = 32'h4135_4135;
  localparam logic [7:0]  LAST_WORD   = 8'(WORDS_PER_FRAME - 1);
  localparam logic [15:0] LAST_POLL   = 16'(POLL_LIMIT - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_RD_ID, S_WR_KEY_LO, S_WR_KEY_HI, S_WR_FRAME, S_WR_LOAD,
    S_POLL, S_READ, S_PUSH, S_NEXT_FRAME, S_DONE
  } state_t;

  state_t      r_state;
  logic [63:0] r_key;
  logic [21:0] r_frame_cnt;
  logic [15:0] r_frames_left;
  logic [7:0]  r_word_cnt;
  logic [15:0] r_poll_cnt;
  logic        r_busy, r_done, r_error;
  logic [31:0] r_ks_data;
  logic        r_ks_valid, r_ks_last;
  logic        r_cyc, r_we;
  logic [3:0]  r_sel;
  logic [31:0] r_adr, r_dat;

  logic        w_bus_state;
  logic        w_ack;
  logic [31:0] w_req_adr;
  logic [31:0] w_req_dat;
  logic        w_req_we;

  // Bus request implied by the current state; issued whenever the state
  // owns the bus and no cycle is open.
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_bus_state = 1'b1;
    w_req_adr   = BASE_ADDR;
    w_req_dat   = 32'h0;
    w_req_we    = 1'b0;
    case (r_state)
      S_RD_ID:     w_req_adr = BASE_ADDR + OFF_ID;
      S_WR_KEY_LO: begin
        w_req_adr = BASE_ADDR + OFF_KEY_LO;
        w_req_dat = r_key[31:0];
        w_req_we  = 1'b1;
      end
      S_WR_KEY_HI: begin
        w_req_adr = BASE_ADDR + OFF_KEY_HI;
        w_req_dat = r_key[63:32];
        w_req_we  = 1'b1;
      end
      S_WR_FRAME: begin
        w_req_adr = BASE_ADDR + OFF_FRAME;
        w_req_dat = {10'b0, r_frame_cnt};
        w_req_we  = 1'b1;
      end
      S_WR_LOAD: begin
        w_req_adr = BASE_ADDR + OFF_CONTROL;
        w_req_dat = 32'h1;
        w_req_we  = 1'b1;
      end
      S_POLL:      w_req_adr = BASE_ADDR + OFF_STATUS;
      S_READ:      w_req_adr = BASE_ADDR + OFF_DATA;
      default:     w_bus_state = 1'b0;
    endcase
  end

  assign w_ack = r_cyc & m_ack_i;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees the pre-edge value of every other register.
  // NOTE: all registers (there is no memory array here) are cleared by the
  // asynchronous reset, which also abandons any open bus cycle at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_key         <= '0;
      r_frame_cnt   <= '0;
      r_frames_left <= '0;
      r_word_cnt    <= '0;
      r_poll_cnt    <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_error       <= 1'b0;
      r_ks_data     <= '0;
      r_ks_valid    <= 1'b0;
      r_ks_last     <= 1'b0;
      r_cyc         <= 1'b0;
      r_we          <= 1'b0;
      r_sel         <= '0;
      r_adr         <= '0;
      r_dat         <= '0;
    end else begin
      r_done <= 1'b0;

      // Open a cycle only from an idle bus: the edge that sees ack closes
      // the cycle, so the next one starts at the earliest one edge later,
      // leaving the required idle cycle in between.
      if (w_bus_state && !r_cyc) begin
        r_cyc <= 1'b1;
        r_sel <= 4'hF;
        r_we  <= w_req_we;
        r_adr <= w_req_adr;
        r_dat <= w_req_dat;
      end
      if (w_ack) begin
        r_cyc <= 1'b0;
        r_we  <= 1'b0;
        r_sel <= 4'h0;
      end

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_error <= 1'b0;
            if (num_frames == 16'd0) begin
              r_done <= 1'b1;
            end else begin
              r_key         <= key;
              r_frame_cnt   <= frame_start;
              r_frames_left <= num_frames;
              r_word_cnt    <= '0;
              r_poll_cnt    <= '0;
              r_busy        <= 1'b1;
              // First cycle goes out on this edge for one-cycle latency.
              r_cyc         <= 1'b1;
              r_sel         <= 4'hF;
`ifdef A5SEQ_ID_CHECK_EN
              r_state       <= S_RD_ID;
              r_we          <= 1'b0;
              r_adr         <= BASE_ADDR + OFF_ID;
              r_dat         <= 32'h0;
`else
              r_state       <= S_WR_KEY_LO;
              r_we          <= 1'b1;
              r_adr         <= BASE_ADDR + OFF_KEY_LO;
              r_dat         <= key[31:0];
`endif
            end
          end
        end
        S_RD_ID: begin
          if (w_ack) begin
            if (m_dat_i == ID_VALUE) begin
              r_state <= S_WR_KEY_LO;
            end else begin
              r_error <= 1'b1;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end
          end
        end
        S_WR_KEY_LO: if (w_ack) r_state <= S_WR_KEY_HI;
        S_WR_KEY_HI: if (w_ack) r_state <= S_WR_FRAME;
        S_WR_FRAME:  if (w_ack) r_state <= S_WR_LOAD;
        S_WR_LOAD:   if (w_ack) r_state <= S_POLL;
        S_POLL: begin
          if (w_ack) begin
            if (m_dat_i[0]) begin
              r_state <= S_READ;
            end else if (r_poll_cnt == LAST_POLL) begin
              r_error <= 1'b1;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_poll_cnt <= r_poll_cnt + 16'd1;
            end
          end
        end
        S_READ: begin
          if (w_ack) begin
            r_ks_data  <= m_dat_i;
            r_ks_valid <= 1'b1;
            r_ks_last  <= (r_word_cnt == LAST_WORD) && (r_frames_left == 16'd1);
            r_poll_cnt <= '0;
            r_state    <= S_PUSH;
          end
        end
        S_PUSH: begin
          if (ks_ready) begin
            r_ks_valid <= 1'b0;
            r_ks_last  <= 1'b0;
            if (r_word_cnt == LAST_WORD) begin
              r_word_cnt <= '0;
              r_state    <= (r_frames_left == 16'd1) ? S_DONE : S_NEXT_FRAME;
            end else begin
              r_word_cnt <= r_word_cnt + 8'd1;
              r_state    <= S_POLL;
            end
          end
        end
        S_NEXT_FRAME: begin
          // 22-bit add wraps 0x3FFFFF to 0 by itself.
          r_frame_cnt   <= r_frame_cnt + 22'd1;
          r_frames_left <= r_frames_left - 16'd1;
          r_state       <= S_WR_FRAME;
        end
        S_DONE: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign error    = r_error;
  assign ks_data  = r_ks_data;
  assign ks_valid = r_ks_valid;
  assign ks_last  = r_ks_last;
  assign m_cyc_o  = r_cyc;
  assign m_stb_o  = r_cyc;
  assign m_we_o   = r_we;
  assign m_sel_o  = r_sel;
  assign m_adr_o  = r_adr;
  assign m_dat_o  = r_dat;

endmodule
